// File: rtl/z_hilo_writeback.sv
// ----------------------------------------------------------------------------
// z_hilo_writeback
//
// Result-capture and writeback stage directly downstream of the ALU.
// Each 64-bit ALU result and its opcode are accepted over a valid/ready
// handshake and held in the 64-bit Z register. The result is then handed to
// the 32-bit datapath bus as one beat (ZLO) or two beats (ZLO then ZHI).
// The stage also owns the architectural HI/LO registers. mul/div write them.
// mfhi/mflo read them back through Z.
//
// Ports
//   clk        in   1       single clock, rising edge
//   clr_n      in   1       asynchronous active-low reset
//   in_valid   in   1       ALU result/opcode valid
//   in_ready   out  1       stage can accept a result (high only in IDLE)
//   opcode     in   5       ALU opcode accompanying result
//   result     in   64      [31:0] low word/quotient, [63:32] high word/remainder
//   bus_valid  out  1       bus_out holds a word beat
//   bus_ready  in   1       bus consumer takes the beat
//   bus_sel    out  1       0 = ZLO beat, 1 = ZHI beat
//   bus_out    out  32      word beat data (zero when no beat)
//   hi_q       out  32      HI register
//   lo_q       out  32      LO register
//   drop_cnt   out  DROP_W  saturating count of discarded results
// ----------------------------------------------------------------------------
module z_hilo_writeback #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [63:0]       result,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_sel,
    output logic [31:0]       bus_out,
    output logic [31:0]       hi_q,
    output logic [31:0]       lo_q,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CLS_COMPUTE = 3'd0,
        CLS_WIDE    = 3'd1,
        CLS_MFHI    = 3'd2,
        CLS_MFLO    = 3'd3,
        CLS_DISCARD = 3'd4
    } op_class_e;

    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;

    // Opcode decode into the classes that steer capture and beat count.
    function automatic op_class_e classify(input logic [4:0] op);
        op_class_e c;
        if ((op >= 5'b00011 && op <= 5'b01110) || op == 5'b10001 || op == 5'b10010)
            c = CLS_COMPUTE;
        else if (op == OP_MUL || op == OP_DIV)
            c = CLS_WIDE;
        else if (op == OP_MFHI)
            c = CLS_MFHI;
        else if (op == OP_MFLO)
            c = CLS_MFLO;
        else
            c = CLS_DISCARD;
        return c;
    endfunction

    // Saturating increment: an all-ones value holds.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        logic [DROP_W-1:0] one;
        one = {{(DROP_W-1){1'b0}}, 1'b1};
        return (&v) ? v : (v + one);
    endfunction

    state_e    state;
    state_e    state_nxt;
    op_class_e cls;
    logic      accept;
    logic      capture;
    logic      drop;

    logic [63:0] z_p0;
    logic        wide_p0;

    assign cls      = classify(opcode);
    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign capture  = accept && (cls != CLS_DISCARD);
    assign drop     = accept && (cls == CLS_DISCARD);

    // ---- state register -------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. A wide result needs the extra HI beat.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (capture)   state_nxt = S_LO;
            S_LO:   if (bus_ready) state_nxt = wide_p0 ? S_HI : S_IDLE;
            S_HI:   if (bus_ready) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // ---- capture stage: Z, HI/LO, discard counter -------------------------
    // HI/LO are written on the same edge that captures a wide result.
    // mfhi/mflo therefore see the value left by the previous mul/div.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            z_p0     <= '0;
            wide_p0  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            drop_cnt <= '0;
        end else begin
            if (capture) begin
                wide_p0 <= (cls == CLS_WIDE);
                unique case (cls)
                    CLS_WIDE: begin
                        z_p0 <= result;
                        hi_q <= result[63:32];
                        lo_q <= result[31:0];
                    end
                    CLS_MFHI: z_p0 <= {32'd0, hi_q};
                    CLS_MFLO: z_p0 <= {32'd0, lo_q};
                    default:  z_p0 <= result;
                endcase
            end
            if (drop)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // ---- bus beat stage ---------------------------------------------------
    // The beat is decoded purely from the state and Z flops. It therefore
    // stays stable while bus_ready is held low.
    always_comb begin
        bus_valid = 1'b0;
        bus_sel   = 1'b0;
        bus_out   = 32'd0;
        unique case (state)
            S_LO: begin
                bus_valid = 1'b1;
                bus_out   = z_p0[31:0];
            end
            S_HI: begin
                bus_valid = 1'b1;
                bus_sel   = 1'b1;
                bus_out   = z_p0[63:32];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_z_hilo_writeback.sv
module tb_z_hilo_writeback;

    logic        clk;
    logic        clr_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [63:0] result;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_sel;
    logic [31:0] bus_out;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [7:0]  drop_cnt;

    // Second instance with a narrow counter for the saturation case.
    logic        in_valid2;
    logic        in_ready2;
    logic [4:0]  opcode2;
    logic        bus_valid2;
    logic        bus_sel2;
    logic [31:0] bus_out2;
    logic [31:0] hi_q2;
    logic [31:0] lo_q2;
    logic [1:0]  drop_cnt2;

    int n_checks;
    int n_pass;

    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [4:0] OP_MFHI  = 5'b11000;
    localparam logic [4:0] OP_MFLO  = 5'b11001;
    localparam logic [4:0] OP_JAL   = 5'b10101;
    localparam logic [4:0] OP_STORE = 5'b00010;
    localparam logic [4:0] OP_RSVD  = 5'b11010;

    z_hilo_writeback #(.DROP_W(8)) dut (
        .clk(clk), .clr_n(clr_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .result(result),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_sel(bus_sel), .bus_out(bus_out),
        .hi_q(hi_q), .lo_q(lo_q), .drop_cnt(drop_cnt)
    );

    z_hilo_writeback #(.DROP_W(2)) dut2 (
        .clk(clk), .clr_n(clr_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .opcode(opcode2), .result(64'h1111_2222_3333_4444),
        .bus_valid(bus_valid2), .bus_ready(1'b1),
        .bus_sel(bus_sel2), .bus_out(bus_out2),
        .hi_q(hi_q2), .lo_q(lo_q2), .drop_cnt(drop_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one result for exactly one rising edge. The block must be ready.
    task automatic send(input logic [4:0] op, input logic [63:0] res);
        check("send_in_ready", 64'(in_ready), 64'd1);
        opcode   = op;
        result   = res;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        clr_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = 5'd0;
        result    = 64'd0;
        bus_ready = 1'b1;
        in_valid2 = 1'b0;
        opcode2   = OP_RSVD;

        // Reset state
        #2;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_bus_valid", 64'(bus_valid), 64'd0);
        check("rst_bus_sel",   64'(bus_sel),   64'd0);
        check("rst_bus_out",   64'(bus_out),   64'd0);
        check("rst_hi",        64'(hi_q),      64'd0);
        check("rst_lo",        64'(lo_q),      64'd0);
        check("rst_drop",      64'(drop_cnt),  64'd0);
        step();
        clr_n = 1'b1;
        @(negedge clk);

        // Compute: add, one beat, latency 1
        send(OP_ADD, 64'h0000_0000_1234_5678);
        @(negedge clk);
        check("add_valid", 64'(bus_valid), 64'd1);
        check("add_sel",   64'(bus_sel),   64'd0);
        check("add_out",   64'(bus_out),   64'h1234_5678);
        check("add_inrdy", 64'(in_ready),  64'd0);
        check("add_hi",    64'(hi_q),      64'd0);
        check("add_lo",    64'(lo_q),      64'd0);
        @(negedge clk);
        check("add_done_valid", 64'(bus_valid), 64'd0);
        check("add_done_inrdy", 64'(in_ready),  64'd1);

        // Mul: two beats, HI/LO visible from the cycle after capture
        send(OP_MUL, 64'h0000_0001_8000_0000);
        @(negedge clk);
        check("mul_lo_valid", 64'(bus_valid), 64'd1);
        check("mul_lo_sel",   64'(bus_sel),   64'd0);
        check("mul_lo_out",   64'(bus_out),   64'h8000_0000);
        check("mul_hi_q",     64'(hi_q),      64'd1);
        check("mul_lo_q",     64'(lo_q),      64'h8000_0000);
        @(negedge clk);
        check("mul_hi_valid", 64'(bus_valid), 64'd1);
        check("mul_hi_sel",   64'(bus_sel),   64'd1);
        check("mul_hi_out",   64'(bus_out),   64'h0000_0001);
        @(negedge clk);
        check("mul_done_valid", 64'(bus_valid), 64'd0);

        // Div then mfhi, mflo
        send(OP_DIV, {32'd3, 32'd7});
        @(negedge clk);
        check("div_lo_out", 64'(bus_out), 64'd7);
        check("div_lo_sel", 64'(bus_sel), 64'd0);
        @(negedge clk);
        check("div_hi_out", 64'(bus_out), 64'd3);
        check("div_hi_sel", 64'(bus_sel), 64'd1);
        step();
        send(OP_MFHI, 64'hDEAD_BEEF_DEAD_BEEF);
        @(negedge clk);
        check("mfhi_valid", 64'(bus_valid), 64'd1);
        check("mfhi_out",   64'(bus_out),   64'd3);
        check("mfhi_sel",   64'(bus_sel),   64'd0);
        step();
        send(OP_MFLO, 64'hDEAD_BEEF_DEAD_BEEF);
        @(negedge clk);
        check("mflo_out", 64'(bus_out), 64'd7);
        check("mflo_sel", 64'(bus_sel), 64'd0);
        @(negedge clk);
        check("mflo_done_valid", 64'(bus_valid), 64'd0);
        check("move_hi", 64'(hi_q), 64'd3);
        check("move_lo", 64'(lo_q), 64'd7);

        // Backpressure: LO beat held six cycles
        bus_ready = 1'b0;
        send(OP_MUL, 64'hAAAA_BBBB_CCCC_DDDD);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_lo_valid", 64'(bus_valid), 64'd1);
            check("bp_lo_sel",   64'(bus_sel),   64'd0);
            check("bp_lo_out",   64'(bus_out),   64'hCCCC_DDDD);
            check("bp_inrdy",    64'(in_ready),  64'd0);
            if (i == 5)
                bus_ready = 1'b1;
        end
        @(negedge clk);
        check("bp_hi_valid", 64'(bus_valid), 64'd1);
        check("bp_hi_sel",   64'(bus_sel),   64'd1);
        check("bp_hi_out",   64'(bus_out),   64'hAAAA_BBBB);
        check("bp_hi_inrdy", 64'(in_ready),  64'd0);
        @(negedge clk);
        check("bp_done_valid", 64'(bus_valid), 64'd0);
        check("bp_done_inrdy", 64'(in_ready),  64'd1);

        // Reset during the HI beat
        bus_ready = 1'b0;
        send(OP_MUL, 64'h0000_0005_0000_0009);
        @(negedge clk);
        check("rm_lo_out", 64'(bus_out), 64'd9);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        @(negedge clk);
        check("rm_hi_sel", 64'(bus_sel), 64'd1);
        check("rm_hi_out", 64'(bus_out), 64'd5);
        check("rm_hi_q",   64'(hi_q),    64'd5);
        #2;
        clr_n = 1'b0;
        #1;
        check("rm_bus_valid", 64'(bus_valid), 64'd0);
        check("rm_bus_out",   64'(bus_out),   64'd0);
        check("rm_bus_sel",   64'(bus_sel),   64'd0);
        check("rm_hi",        64'(hi_q),      64'd0);
        check("rm_lo",        64'(lo_q),      64'd0);
        step();
        clr_n = 1'b1;
        @(negedge clk);
        check("rm_inrdy",     64'(in_ready),  64'd1);
        check("rm_idle_valid", 64'(bus_valid), 64'd0);
        bus_ready = 1'b1;
        send(OP_ADD, 64'h0000_0000_0000_00FF);
        @(negedge clk);
        check("rm_add_valid", 64'(bus_valid), 64'd1);
        check("rm_add_out",   64'(bus_out),   64'h0000_00FF);
        @(negedge clk);
        check("rm_add_done",  64'(bus_valid), 64'd0);

        // Discards: jal, store
        send(OP_JAL, 64'h1234_1234_1234_1234);
        @(negedge clk);
        check("jal_valid", 64'(bus_valid), 64'd0);
        check("jal_inrdy", 64'(in_ready),  64'd1);
        check("jal_drop",  64'(drop_cnt),  64'd1);
        send(OP_STORE, 64'h5678_5678_5678_5678);
        @(negedge clk);
        check("store_valid", 64'(bus_valid), 64'd0);
        check("store_drop",  64'(drop_cnt),  64'd2);
        check("drop_hi",     64'(hi_q),      64'd0);
        check("drop_lo",     64'(lo_q),      64'd0);

        // Saturation with a 2-bit counter: five back-to-back discards
        in_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_drop",   64'(drop_cnt2),  64'((i + 1 > 3) ? 3 : i + 1));
            check("sat_valid",  64'(bus_valid2), 64'd0);
            check("sat_inrdy",  64'(in_ready2),  64'd1);
        end
        in_valid2 = 1'b0;
        step();
        check("sat_hold",   64'(drop_cnt2), 64'd3);
        check("sat_sel",    64'(bus_sel2),  64'd0);
        check("sat_out",    64'(bus_out2),  64'd0);
        check("sat_hi",     64'(hi_q2),     64'd0);
        check("sat_lo",     64'(lo_q2),     64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/z_hilo_writeback.md
# z_hilo_writeback

- Result-capture and writeback stage sitting directly downstream of the ALU.
- Accepts each 64-bit ALU result with its opcode over a valid/ready handshake and holds it in the internal 64-bit Z register.
- Presents it to the 32-bit datapath bus as one or two word beats (ZLO, then ZHI), also over a valid/ready handshake.
- Maintains the architectural HI/LO registers written by `mul`/`div` and read back by `mfhi`/`mflo`.

## Interface
Parameters:
- `DROP_W`, 8, width of the discarded-opcode counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  ALU result and opcode valid.
- `in_ready`  out  1  block can accept a result.
- `opcode`  in  5  ALU opcode accompanying `result`.
- `result`  in  64  ALU result: `[31:0]` low word/quotient, `[63:32]` high word/remainder.
- `bus_valid`  out  1  `bus_out` holds a word beat.
- `bus_ready`  in  1  bus consumer takes the beat.
- `bus_sel`  out  1  0 = low word (ZLO), 1 = high word (ZHI).
- `bus_out`  out  32  word beat data.
- `hi_q`  out  32  HI register.
- `lo_q`  out  32  LO register.
- `drop_cnt`  out  DROP_W  count of accepted results that were discarded; saturating.

## Operation
Opcode classes:
- **Compute:** 5'b00011–5'b01110, 5'b10001, 5'b10010. One beat: ZLO = `result[31:0]`.
- **Wide:** `mul` 5'b01111 and `div` 5'b10000. Two beats: ZLO, then ZHI.
  - At the capture edge, HI <= `result[63:32]` and LO <= `result[31:0]` (div: HI = remainder, LO = quotient).
- **Move:** `mfhi` 5'b11000 and `mflo` 5'b11001.
  - Z <= {32'd0, hi_q} or {32'd0, lo_q}, using the pre-edge HI/LO values.
  - One beat. HI/LO unchanged.
- **Discard:** all other opcodes (load, loadImm, store, branch, jr, jal, in, out, 5'b11010–5'b11111).
  - The handshake completes; no beat is produced.
  - `drop_cnt` increments, saturating at all-ones. Z is unchanged.

States: IDLE, LO, HI.
- IDLE: `in_ready` = 1. On `in_valid`:
  - compute / wide / move: capture Z and opcode; go to LO.
  - discard: stay in IDLE.
- LO: `bus_valid` = 1, `bus_sel` = 0, `bus_out` = Z[31:0]. On `bus_ready`: wide goes to HI, otherwise to IDLE.
- HI: `bus_valid` = 1, `bus_sel` = 1, `bus_out` = Z[63:32]. On `bus_ready`: go to IDLE.

Output rules:
- `in_ready` = (state == IDLE).
- `bus_out` = 0 and `bus_sel` = 0 whenever `bus_valid` = 0.
- `bus_valid`, `bus_sel` and `bus_out` are registered (driven from state/Z flops, not from inputs).

## Timing
- Reset (`clr_n` low, asynchronous): state = IDLE, Z = 0, HI = 0, LO = 0, `drop_cnt` = 0, `bus_valid` = 0, `bus_sel` = 0, `bus_out` = 0, `in_ready` = 1.
- Reset asserted mid-transfer (LO or HI) aborts the transfer: no further beat, and the HI/LO values already written are cleared.
- Capture edge = rising edge with `in_valid` && `in_ready`. The first beat is valid in the following cycle, so latency is 1 cycle.
- Beat transfer = rising edge with `bus_valid` && `bus_ready`.
  - The next beat is valid in the cycle after a transfer.
  - If `bus_ready` is held low, `bus_valid`, `bus_sel` and `bus_out` stay stable indefinitely.
- Throughput with `bus_ready` tied high:
  - compute / move: 2 cycles per result.
  - wide: 3 cycles per result.
  - discard: 1 cycle per result.
- `in_ready` is low in LO and HI, so a new result is never accepted while a beat is pending.
- `mfhi`/`mflo` accepted on the cycle after a `mul`/`div` completes (back in IDLE) reads the updated HI/LO.
- HI/LO update at the wide capture edge; `hi_q`/`lo_q` show new values from the next cycle, before the beats are sent.
- `drop_cnt` saturation: at all-ones, further discards leave it unchanged.

## Test plan
- **Compute:** `add` (5'b00011), result = 64'h0000_0000_1234_5678, `bus_ready` = 1.
  - One beat, `bus_sel` = 0, `bus_out` = 32'h1234_5678, one cycle after capture. HI/LO stay 0.
- **Mul:** `mul`, result = 64'h0000_0001_8000_0000.
  - Beats 32'h8000_0000 (sel 0) then 32'h0000_0001 (sel 1) on consecutive cycles.
  - `hi_q` = 1 and `lo_q` = 32'h8000_0000 from the cycle after capture.
- **Div then move:** `div` with result = {32'd3, 32'd7}, then `mfhi`, then `mflo`.
  - Beats 7, 3; then 3 (sel 0); then 7 (sel 0). HI/LO unchanged by the moves.
- **Backpressure:** `mul` with `bus_ready` held low for 5 cycles during LO, then high.
  - The LO beat is stable for all 6 cycles. `in_ready` = 0 throughout.
  - The HI beat follows the transfer, then `in_ready` returns to 1.
- **Reset mid-transfer:** `clr_n` pulsed low asynchronously while in HI with `bus_ready` = 0.
  - `bus_valid` and `bus_out` go to 0 immediately; `hi_q` = `lo_q` = 0; `in_ready` = 1 after release.
  - The next `add` transfers normally.
- **Discard:** `jal` (5'b10101), then `store`, each with `in_valid` for one cycle.
  - Each is accepted in one cycle; no `bus_valid`; `drop_cnt` = 2; Z/HI/LO unchanged.
  - With `DROP_W` = 2, a run of 5 discards saturates `drop_cnt` at 3.
